// File: rtl/conv1_calc_if.sv
// Bundle of window taps, coefficient-write port and result signals for conv1_calc.
interface conv1_calc_if #(
    parameter int DATA_BITS = 32
);
    logic [DATA_BITS-1:0] data_in_0;
    logic [DATA_BITS-1:0] data_in_1;
    logic [DATA_BITS-1:0] data_in_2;
    logic [DATA_BITS-1:0] data_in_3;
    logic [DATA_BITS-1:0] data_in_4;
    logic [DATA_BITS-1:0] data_in_5;
    logic [DATA_BITS-1:0] data_in_6;
    logic [DATA_BITS-1:0] data_in_7;
    logic [DATA_BITS-1:0] data_in_8;
    logic                 valid_in;
    logic                 w_wr_en;
    logic [3:0]           w_wr_addr;
    logic [DATA_BITS-1:0] w_wr_data;
    logic [DATA_BITS-1:0] conv_out;
    logic                 valid_out_conv;
    logic                 frame_done;

    modport master (
        output data_in_0, data_in_1, data_in_2, data_in_3, data_in_4,
               data_in_5, data_in_6, data_in_7, data_in_8,
               valid_in, w_wr_en, w_wr_addr, w_wr_data,
        input  conv_out, valid_out_conv, frame_done
    );

    modport slave (
        input  data_in_0, data_in_1, data_in_2, data_in_3, data_in_4,
               data_in_5, data_in_6, data_in_7, data_in_8,
               valid_in, w_wr_en, w_wr_addr, w_wr_data,
        output conv_out, valid_out_conv, frame_done
    );
endinterface

// File: rtl/conv1_calc.sv
// Pipelined 3x3 fixed-point convolution: products, row sums, accumulate, then
// ReLU/saturate into the output register, with a per-frame done pulse.
module conv1_calc #(
    parameter int WIDTH     = 28,
    parameter int HEIGHT    = 36,
    parameter int DATA_BITS = 32,
    parameter int FRAC_BITS = 16,
    parameter int RELU_EN   = 1
) (
    input  logic       clk,
    input  logic       rst,
    conv1_calc_if.slave bus
);
    localparam int PROD_W  = 2 * DATA_BITS;
    localparam int ROW_W   = PROD_W + 2;
    localparam int ACC_W   = PROD_W + 4;
    localparam int FRAME_N = (WIDTH - 2) * (HEIGHT - 2);
    localparam int CNT_W   = (FRAME_N > 1) ? $clog2(FRAME_N) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_N - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_BITS + 1){1'b0}}, {(DATA_BITS - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - DATA_BITS + 1){1'b1}}, {(DATA_BITS - 1){1'b0}}};

    logic signed [DATA_BITS-1:0] w_tap [9];
    logic signed [DATA_BITS-1:0] r_weight [9];
    logic signed [DATA_BITS-1:0] r_bias;
    logic signed [PROD_W-1:0]    r_prod [9];
    logic signed [DATA_BITS-1:0] r_biasS1;
    logic signed [ROW_W-1:0]     r_row [3];
    logic signed [DATA_BITS-1:0] r_biasS2;
    logic signed [ACC_W-1:0]     r_acc;
    logic [2:0]                  r_validPipe;
    logic [DATA_BITS-1:0]        r_convOut;
    logic                        r_validOut;
    logic [CNT_W-1:0]            r_frameCount;
    logic                        r_frameDone;
    logic signed [ACC_W-1:0]     w_shifted;
    logic signed [ACC_W-1:0]     w_relu;
    logic [DATA_BITS-1:0]        w_satOut;

    assign w_tap[0] = bus.data_in_0;
    assign w_tap[1] = bus.data_in_1;
    assign w_tap[2] = bus.data_in_2;
    assign w_tap[3] = bus.data_in_3;
    assign w_tap[4] = bus.data_in_4;
    assign w_tap[5] = bus.data_in_5;
    assign w_tap[6] = bus.data_in_6;
    assign w_tap[7] = bus.data_in_7;
    assign w_tap[8] = bus.data_in_8;

    // Coefficient file; a window sampled on the write edge still sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) r_weight[k] <= '0;
            r_bias <= '0;
        end else if (bus.w_wr_en) begin
            for (int k = 0; k < 9; k++) begin
                if (bus.w_wr_addr == 4'(k)) r_weight[k] <= bus.w_wr_data;
            end
            if (bus.w_wr_addr == 4'd9) r_bias <= bus.w_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) r_prod[k] <= '0;
            r_biasS1 <= '0;
        end else if (bus.valid_in) begin
            for (int k = 0; k < 9; k++) r_prod[k] <= PROD_W'(w_tap[k]) * PROD_W'(r_weight[k]);
            r_biasS1 <= r_bias;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) r_row[r] <= '0;
            r_biasS2 <= '0;
        end else if (r_validPipe[0]) begin
            for (int r = 0; r < 3; r++) begin
                r_row[r] <= ROW_W'(r_prod[3*r]) + ROW_W'(r_prod[3*r+1]) + ROW_W'(r_prod[3*r+2]);
            end
            r_biasS2 <= r_biasS1;
        end
    end

    // Bias is aligned to the Q(2*FRAC) product scale before it joins the row sums.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (r_validPipe[1]) begin
            r_acc <= ACC_W'(r_row[0]) + ACC_W'(r_row[1]) + ACC_W'(r_row[2])
                   + (ACC_W'(r_biasS2) <<< FRAC_BITS);
        end
    end

    assign w_shifted = r_acc >>> FRAC_BITS;
    assign w_relu    = ((RELU_EN != 0) && w_shifted[ACC_W-1]) ? '0 : w_shifted;

    always_comb begin
        w_satOut = w_relu[DATA_BITS-1:0];
        if (w_relu > SAT_MAX) begin
            w_satOut = SAT_MAX[DATA_BITS-1:0];
        end else if (w_relu < SAT_MIN) begin
            w_satOut = SAT_MIN[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_validPipe <= '0;
            r_validOut  <= 1'b0;
            r_convOut   <= '0;
        end else begin
            r_validPipe <= {r_validPipe[1:0], bus.valid_in};
            r_validOut  <= r_validPipe[2];
            if (r_validPipe[2]) r_convOut <= w_satOut;
        end
    end

    // Counts outputs as they are registered so the pulse lines up with the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frameCount <= '0;
            r_frameDone  <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            if (r_validPipe[2]) begin
                if (r_frameCount == LAST_IDX) begin
                    r_frameCount <= '0;
                    r_frameDone  <= 1'b1;
                end else begin
                    r_frameCount <= r_frameCount + 1'b1;
                end
            end
        end
    end

    assign bus.conv_out       = r_convOut;
    assign bus.valid_out_conv = r_validOut;
    assign bus.frame_done     = r_frameDone;
endmodule

// File: tb/tb_conv1_calc.sv
// Directed bench for conv1_calc: one ReLU instance and one linear instance driven
// with identical windows and coefficient writes.
module tb_conv1_calc;
    localparam logic [31:0] ONE = 32'h0001_0000;

    logic        clk;
    logic        rst;
    logic [31:0] tapVal [9];
    logic        validIn;
    logic        wrEn;
    logic [3:0]  wrAddr;
    logic [31:0] wrData;
    int          testCount;
    int          failCount;

    conv1_calc_if #(.DATA_BITS(32)) ifRelu ();
    conv1_calc_if #(.DATA_BITS(32)) ifLin ();

    assign ifRelu.data_in_0 = tapVal[0];
    assign ifRelu.data_in_1 = tapVal[1];
    assign ifRelu.data_in_2 = tapVal[2];
    assign ifRelu.data_in_3 = tapVal[3];
    assign ifRelu.data_in_4 = tapVal[4];
    assign ifRelu.data_in_5 = tapVal[5];
    assign ifRelu.data_in_6 = tapVal[6];
    assign ifRelu.data_in_7 = tapVal[7];
    assign ifRelu.data_in_8 = tapVal[8];
    assign ifRelu.valid_in  = validIn;
    assign ifRelu.w_wr_en   = wrEn;
    assign ifRelu.w_wr_addr = wrAddr;
    assign ifRelu.w_wr_data = wrData;

    assign ifLin.data_in_0 = tapVal[0];
    assign ifLin.data_in_1 = tapVal[1];
    assign ifLin.data_in_2 = tapVal[2];
    assign ifLin.data_in_3 = tapVal[3];
    assign ifLin.data_in_4 = tapVal[4];
    assign ifLin.data_in_5 = tapVal[5];
    assign ifLin.data_in_6 = tapVal[6];
    assign ifLin.data_in_7 = tapVal[7];
    assign ifLin.data_in_8 = tapVal[8];
    assign ifLin.valid_in  = validIn;
    assign ifLin.w_wr_en   = wrEn;
    assign ifLin.w_wr_addr = wrAddr;
    assign ifLin.w_wr_data = wrData;

    conv1_calc #(.WIDTH(28), .HEIGHT(36), .DATA_BITS(32), .FRAC_BITS(16), .RELU_EN(1))
        dutRelu (.clk(clk), .rst(rst), .bus(ifRelu.slave));

    conv1_calc #(.WIDTH(28), .HEIGHT(36), .DATA_BITS(32), .FRAC_BITS(16), .RELU_EN(0))
        dutLin (.clk(clk), .rst(rst), .bus(ifLin.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: inputs set beforehand are sampled, outputs are read 1 time unit later.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic writeCoef(input logic [3:0] addr, input logic [31:0] data);
        wrEn   = 1'b1;
        wrAddr = addr;
        wrData = data;
        applyStimulus();
        wrEn   = 1'b0;
    endtask

    task automatic loadAllWeights(input logic [31:0] data);
        for (int k = 0; k < 9; k++) writeCoef(4'(k), data);
    endtask

    task automatic setAllTaps(input logic [31:0] data);
        for (int k = 0; k < 9; k++) tapVal[k] = data;
    endtask

    // Present one window, then idle until its result is on the outputs.
    task automatic runWindow();
        validIn = 1'b1;
        applyStimulus();
        validIn = 1'b0;
        repeat (3) applyStimulus();
    endtask

    initial begin
        int       sent;
        int       outIdx;
        int       pulses;
        int       firstPulse;
        int       pulseBad;
        int       validBad;
        int       idleBad;
        logic     v;
        logic [3:0] hist;

        testCount = 0;
        failCount = 0;
        rst       = 1'b1;
        validIn   = 1'b0;
        wrEn      = 1'b0;
        wrAddr    = 4'd0;
        wrData    = 32'd0;
        setAllTaps(32'd0);

        #7;
        checkOutput("reset_conv_out", ifRelu.conv_out, 32'd0);
        checkOutput("reset_valid", 32'(ifRelu.valid_out_conv), 32'd0);
        checkOutput("reset_frame_done", 32'(ifRelu.frame_done), 32'd0);
        #1 rst = 1'b0;

        // Two frames of windows with a sparse gap pattern.
        sent = 0; outIdx = 0; pulses = 0; firstPulse = 0; pulseBad = 0; validBad = 0;
        hist = 4'd0;
        for (int i = 0; i < 2400; i++) begin
            v = (sent < 1768) && (i % 7 != 3) && !((i % 50) >= 20 && (i % 50) < 23);
            validIn = v;
            applyStimulus();
            if (v) sent++;
            hist = {hist[2:0], v};
            if (ifRelu.valid_out_conv !== hist[3]) validBad++;
            if (ifRelu.valid_out_conv === 1'b1) outIdx++;
            if (ifRelu.frame_done === 1'b1) begin
                pulses++;
                if (firstPulse == 0) firstPulse = outIdx;
                if (ifRelu.valid_out_conv !== 1'b1 || (outIdx != 884 && outIdx != 1768)) pulseBad++;
            end
        end
        validIn = 1'b0;
        checkOutput("frame_valid_pattern", 32'(validBad), 32'd0);
        checkOutput("frame_output_count", 32'(outIdx), 32'd1768);
        checkOutput("frame_pulse_count", 32'(pulses), 32'd2);
        checkOutput("frame_first_pulse_at", 32'(firstPulse), 32'd884);
        checkOutput("frame_pulse_position", 32'(pulseBad), 32'd0);

        // All-ones window against unit weights.
        loadAllWeights(ONE);
        writeCoef(4'd9, 32'd0);
        setAllTaps(ONE);
        validIn = 1'b1;
        applyStimulus();
        validIn = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("sum9_not_early", 32'(ifRelu.valid_out_conv), 32'd0);
        applyStimulus();
        checkOutput("sum9_valid", 32'(ifRelu.valid_out_conv), 32'd1);
        checkOutput("sum9_relu", ifRelu.conv_out, 32'h0009_0000);
        checkOutput("sum9_lin", ifLin.conv_out, 32'h0009_0000);
        applyStimulus();
        checkOutput("sum9_single_valid", 32'(ifRelu.valid_out_conv), 32'd0);
        checkOutput("sum9_hold", ifRelu.conv_out, 32'h0009_0000);

        // Negative result with fractional bias: -2.0 + 0.5.
        loadAllWeights(32'd0);
        writeCoef(4'd4, 32'hFFFF_0000);
        writeCoef(4'd9, 32'h0000_8000);
        setAllTaps(32'd0);
        tapVal[4] = 32'h0002_0000;
        runWindow();
        checkOutput("neg_valid", 32'(ifLin.valid_out_conv), 32'd1);
        checkOutput("neg_relu", ifRelu.conv_out, 32'h0000_0000);
        checkOutput("neg_lin", ifLin.conv_out, 32'hFFFE_8000);

        // 0.5 * (-65535/65536) = -0.4999923..., floors to -0.5.
        writeCoef(4'd9, 32'd0);
        writeCoef(4'd0, 32'h0000_8000);
        setAllTaps(32'd0);
        tapVal[0] = 32'hFFFF_0001;
        runWindow();
        checkOutput("floor_lin", ifLin.conv_out, 32'hFFFF_8000);
        checkOutput("floor_relu", ifRelu.conv_out, 32'h0000_0000);

        // Saturation at both rails.
        loadAllWeights(32'h7FFF_FFFF);
        setAllTaps(32'h7FFF_FFFF);
        runWindow();
        checkOutput("sat_pos_relu", ifRelu.conv_out, 32'h7FFF_FFFF);
        checkOutput("sat_pos_lin", ifLin.conv_out, 32'h7FFF_FFFF);
        loadAllWeights(32'h8000_0000);
        runWindow();
        checkOutput("sat_neg_lin", ifLin.conv_out, 32'h8000_0000);
        checkOutput("sat_neg_relu", ifRelu.conv_out, 32'h0000_0000);

        // Weight update on the same edge as window A; window B follows immediately.
        loadAllWeights(32'd0);
        writeCoef(4'd0, ONE);
        setAllTaps(32'd0);
        tapVal[0] = ONE;
        validIn = 1'b1;
        wrEn    = 1'b1;
        wrAddr  = 4'd0;
        wrData  = 32'h0002_0000;
        applyStimulus();
        wrEn = 1'b0;
        applyStimulus();
        validIn = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("wupd_a_valid", 32'(ifRelu.valid_out_conv), 32'd1);
        checkOutput("wupd_a_old_weight", ifRelu.conv_out, 32'h0001_0000);
        applyStimulus();
        checkOutput("wupd_b_valid", 32'(ifRelu.valid_out_conv), 32'd1);
        checkOutput("wupd_b_new_weight", ifRelu.conv_out, 32'h0002_0000);
        applyStimulus();
        checkOutput("wupd_gap", 32'(ifRelu.valid_out_conv), 32'd0);

        // Asynchronous reset with two windows in flight.
        validIn = 1'b1;
        applyStimulus();
        applyStimulus();
        validIn = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_valid", 32'(ifRelu.valid_out_conv), 32'd0);
        checkOutput("rst_async_conv_out", ifRelu.conv_out, 32'd0);
        applyStimulus();
        #3 rst = 1'b0;
        idleBad = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            if (ifRelu.valid_out_conv !== 1'b0 || ifLin.valid_out_conv !== 1'b0) idleBad++;
        end
        checkOutput("rst_flushed", 32'(idleBad), 32'd0);
        validIn = 1'b1;
        applyStimulus();
        validIn = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("restart_not_early", 32'(ifRelu.valid_out_conv), 32'd0);
        applyStimulus();
        checkOutput("restart_valid", 32'(ifRelu.valid_out_conv), 32'd1);
        checkOutput("restart_cleared_coef", ifLin.conv_out, 32'd0);
        checkOutput("restart_no_frame_done", 32'(ifRelu.frame_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule

// File: doc/conv1_calc.md
# conv1_calc

Pipelined 3x3 convolution datapath directly downstream of the `conv1_buf` window buffer. It consumes one 3x3 window per cycle, qualified by the buffer's valid flag. Each window is multiplied by nine programmable signed fixed-point weights and summed with a bias, with optional ReLU and saturation. The result is one feature-map value per cycle after a fixed 3-cycle latency, plus a frame-done pulse after the last output of each frame.

## Interface
Parameters:
- `WIDTH`, 28: input row width; sets frame output count.
- `HEIGHT`, 36: input row count; sets frame output count.
- `DATA_BITS`, 32: width of data, weights, bias and result; signed two's complement.
- `FRAC_BITS`, 16: fractional bits of the fixed-point format (Q(DATA_BITS-FRAC_BITS).FRAC_BITS).
- `RELU_EN`, 1: 1 = clamp negative results to 0.

Ports:
- `clk`, in, 1: the single clock for the block.
- `rst`, in, 1: reset, asynchronous, active-high.
- `data_in_0`..`data_in_8`, in, DATA_BITS each: window taps in row-major order (0..2 top row, 6..8 bottom row).
- `valid_in`, in, 1: window valid, driven by the buffer's `valid_out_buf`.
- `w_wr_en`, in, 1: coefficient write strobe.
- `w_wr_addr`, in, 4: addresses 0..8 select weight k for tap k; 9 selects the bias; 10..15 are ignored.
- `w_wr_data`, in, DATA_BITS: coefficient value in Q format.
- `conv_out`, out, DATA_BITS: convolution result.
- `valid_out_conv`, out, 1: `conv_out` is valid this cycle.
- `frame_done`, out, 1: one-cycle pulse coincident with the last valid output of a frame.

## Operation
- Coefficient file: 9 weight registers and 1 bias register, all reset to 0.
  - A write is applied at the clock edge where `w_wr_en`=1.
  - The new value affects windows sampled on the following edge onward.
  - Writes during streaming are legal.
- Stage 1, on `valid_in`: register the 9 products `data_in_k * w_k`, each a signed 2·DATA_BITS value. Register `bias` alongside them.
- Stage 2: register three row partial sums (products 0-2, 3-5, 6-8).
- Stage 3:
  - Compute `acc = row0 + row1 + row2 + (bias <<< FRAC_BITS)`. The accumulator is 2·DATA_BITS+4 bits; no intermediate overflow is allowed.
  - Compute `res = acc >>> FRAC_BITS`, an arithmetic shift that truncates toward −inf.
  - If `RELU_EN` and res<0, then res=0.
  - Saturate res to [−2^(DATA_BITS−1), 2^(DATA_BITS−1)−1] and register it into `conv_out`.
- Valid pipeline: a 3-bit shift register carries `valid_in` alongside the data. Stages whose valid bit is 0 do not update their data registers; they hold their previous value.
- `conv_out` holds its last value while `valid_out_conv`=0.
- Frame counter:
  - Counts valid outputs from 0 to N−1, where N=(WIDTH−2)·(HEIGHT−2) (884 with defaults).
  - On output N−1, `frame_done`=1 for that cycle and the counter wraps to 0.
  - Its width is clog2(N).

## Timing
- Reset values: `conv_out`=0, `valid_out_conv`=0, `frame_done`=0. The valid pipeline, frame counter, weights, bias and all stage registers are 0.
- Latency: a window sampled with `valid_in`=1 at edge t appears at edge t+3, with `valid_out_conv`=1.
- Throughput: 1 window/cycle with no stalls; there is no backpressure input.
- `valid_in` gaps propagate unchanged, so the output valid pattern equals the input pattern delayed by 3 cycles.
- A coefficient write at edge t combined with `valid_in`=1 at edge t: that window uses the old coefficient. A window at edge t+1 uses the new one.
- A reset asserted mid-stream clears the valid pipeline and frame counter immediately (asynchronous). No output valid appears until 3 edges after the first post-reset `valid_in`. Coefficients are also cleared and must be reloaded.
- `frame_done` is never asserted without `valid_out_conv`.

## Test plan
- Load all weights with 0x00010000 (1.0) and bias 0. Present one window with all taps 0x00010000 -> 3 cycles later `conv_out`=0x00090000, valid for exactly 1 cycle.
- Load weights w4=0xFFFF0000 (−1.0), others 0, and bias 0x00008000 (0.5). Set tap4=0x00020000 -> with `RELU_EN`=1 the output is 0x00000000; with `RELU_EN`=0 it is 0xFFFE8000 (−1.5).
- Saturation: all weights and taps 0x7FFFFFFF -> `conv_out`=0x7FFFFFFF. With weights 0x80000000 and taps 0x7FFFFFFF under `RELU_EN`=0 -> 0x80000000.
- Stream 884 consecutive valid windows with gaps inserted -> `frame_done` pulses only with output 884. The next frame's 884th output pulses it again.
- Write w0 from 1.0 to 2.0 on the same edge as window A (tap0=1.0, others 0), with window B identical on the next edge -> outputs 0x00010000, then 0x00020000.
- Assert `rst` asynchronously with 2 windows in flight -> `valid_out_conv` falls immediately and stays 0. Outputs restart 3 cycles after new `valid_in`, with a zero result until coefficients are reloaded.
